// File: rtl/alu.sv
// 64-bit ALU: pass-B, add, subtract, AND, OR and XOR, with a registered flag copy.
// Ports: clk, reset (sync, active-low), A/B operands, cntrl op select,
//        result and combinational flags, flags_q = {n, z, v, c} one cycle late.
module alu (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] A,
    input  logic [63:0] B,
    input  logic [2:0]  cntrl,
    output logic [63:0] result,
    output logic        negative,
    output logic        zero,
    output logic        overflow,
    output logic        carry_out,
    output logic [3:0]  flags_q
);

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;

    logic        is_sub;
    logic [63:0] b_op;
    logic [63:0] sum;
    logic        c_in63;
    logic        c_out63;
    logic [62:0] low_sum;
    logic [3:0]  flags_d;

    // One adder serves both add and sub: subtract is A + ~B + 1.
    assign is_sub = (cntrl == OP_SUB);
    assign b_op   = is_sub ? ~B : B;

    // Low 63 bits summed separately to expose the carry into bit 63,
    // which overflow needs alongside the carry out of bit 63.
    assign {c_in63, low_sum} = {1'b0, A[62:0]} + {1'b0, b_op[62:0]}
                             + {63'd0, is_sub};
    assign {c_out63, sum[63]} = {1'b0, A[63]} + {1'b0, b_op[63]}
                              + {1'b0, c_in63};
    assign sum[62:0] = low_sum;

    always_comb begin
        result    = 64'h0;
        overflow  = 1'b0;
        carry_out = 1'b0;
        case (cntrl)
            OP_PASS: result = B;
            OP_ADD, OP_SUB: begin
                result    = sum;
                overflow  = c_in63 ^ c_out63;
                carry_out = c_out63;
            end
            OP_AND:  result = A & B;
            OP_OR:   result = A | B;
            OP_XOR:  result = A ^ B;
            default: result = 64'h0;
        endcase
    end

    assign negative = result[63];
    assign zero     = ~|result;

    // Reset wins over the load.
    always_comb begin
        flags_d = 4'b0000;
        if (reset) begin
            flags_d = {negative, zero, overflow, carry_out};
        end
    end

    always_ff @(posedge clk) begin
        flags_q <= flags_d;
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors, random ops vs a
// behavioural model, and flags_q latency/reset behaviour.
module tb_alu;

    logic        clk;
    logic        reset;
    logic [63:0] A;
    logic [63:0] B;
    logic [2:0]  cntrl;
    logic [63:0] result;
    logic        negative;
    logic        zero;
    logic        overflow;
    logic        carry_out;
    logic [3:0]  flags_q;

    int compared;
    int mismatched;

    alu dut (
        .clk       (clk),
        .reset     (reset),
        .A         (A),
        .B         (B),
        .cntrl     (cntrl),
        .result    (result),
        .negative  (negative),
        .zero      (zero),
        .overflow  (overflow),
        .carry_out (carry_out),
        .flags_q   (flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain arithmetic and sign rules, no adder carries.
    function automatic void model(
        input  logic [2:0]  op,
        input  logic [63:0] a,
        input  logic [63:0] b,
        output logic [63:0] r,
        output logic [3:0]  f
    );
        logic v;
        logic c;
        v = 1'b0;
        c = 1'b0;
        case (op)
            3'b000: r = b;
            3'b010: begin
                r = a + b;
                c = (r < a);
                v = (a[63] == b[63]) && (r[63] != a[63]);
            end
            3'b011: begin
                r = a - b;
                c = (a >= b);
                v = (a[63] != b[63]) && (r[63] != a[63]);
            end
            3'b100: r = a & b;
            3'b101: r = a | b;
            3'b110: r = a ^ b;
            default: r = 64'h0;
        endcase
        f = {r[63], (r == 64'h0), v, c};
    endfunction

    task automatic chk(
        input string       tag,
        input logic [63:0] obs,
        input logic [63:0] exp
    );
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one vector just after a rising edge, check the
    // combinational outputs, then check flags_q after the next edge.
    task automatic step(
        input string       tag,
        input logic [2:0]  op,
        input logic [63:0] a,
        input logic [63:0] b,
        input logic        rst_n
    );
        logic [63:0] er;
        logic [3:0]  ef;
        logic [3:0]  obs_f;
        cntrl = op;
        A     = a;
        B     = b;
        reset = rst_n;
        model(op, a, b, er, ef);
        #2;
        obs_f = {negative, zero, overflow, carry_out};
        chk({tag, ".result"}, result, er);
        chk({tag, ".flags"}, {60'd0, obs_f}, {60'd0, ef});
        @(posedge clk);
        #1;
        chk({tag, ".flags_q"}, {60'd0, flags_q},
            {60'd0, (rst_n ? ef : 4'b0000)});
    endtask

    function automatic logic [63:0] rnd64();
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 5))
            0: v = 64'h0;
            1: v = 64'hFFFF_FFFF_FFFF_FFFF;
            2: v = 64'h8000_0000_0000_0000;
            3: v = 64'h7FFF_FFFF_FFFF_FFFF;
            default: v = v;
        endcase
        return v;
    endfunction

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        logic [2:0]  rop;
        compared   = 0;
        mismatched = 0;
        reset = 1'b0;
        A     = 64'h0;
        B     = 64'h0;
        cntrl = 3'b000;
        @(posedge clk);
        #1;
        chk("reset_state", {60'd0, flags_q}, 64'd0);

        step("add_1_1", 3'b010, 64'd1, 64'd1, 1'b1);
        step("add_ovf", 3'b010, 64'h4000_0000_0000_0000,
             64'h4000_0000_0000_0000, 1'b1);
        step("add_carry", 3'b010, 64'hFFFF_FFFF_FFFF_FFFF,
             64'd1, 1'b1);
        step("sub_1_1", 3'b011, 64'd1, 64'd1, 1'b1);
        step("sub_ff_1", 3'b011, 64'hFFFF_FFFF_FFFF_FFFF,
             64'd1, 1'b1);
        step("sub_borrow", 3'b011, 64'd0, 64'd1, 1'b1);
        step("sub_ovf", 3'b011, 64'h8000_0000_0000_0000,
             64'd1, 1'b1);
        step("and_zero", 3'b100, 64'hAAAA_AAAA_AAAA_AAAA,
             64'h5555_5555_5555_5555, 1'b1);
        step("and_ones", 3'b100, 64'hAAAA_AAAA_AAAA_AAAA,
             64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        step("or_ones", 3'b101, 64'hAAAA_AAAA_AAAA_AAAA,
             64'h5555_5555_5555_5555, 1'b1);
        step("xor", 3'b110, 64'hFAFA_FAFA_FAFA_FAFA,
             64'hF5F5_F5F5_F5F5_F5F5, 1'b1);
        step("rsv_001", 3'b001, 64'hFFFF_FFFF_FFFF_FFFF,
             64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        step("rsv_111", 3'b111, 64'h8000_0000_0000_0000,
             64'h1234_5678_9ABC_DEF0, 1'b1);

        // Absolute spot checks independent of the model.
        cntrl = 3'b010;
        A = 64'h4000_0000_0000_0000;
        B = 64'h4000_0000_0000_0000;
        #2;
        chk("abs_add_ovf", {60'd0, negative, zero, overflow, carry_out},
            64'h0000_0000_0000_000A);
        cntrl = 3'b110;
        A = 64'hFAFA_FAFA_FAFA_FAFA;
        B = 64'hF5F5_F5F5_F5F5_F5F5;
        #2;
        chk("abs_xor", result, 64'h0F0F_0F0F_0F0F_0F0F);
        @(posedge clk);
        #1;

        for (int i = 0; i < 100; i++) begin
            step("pass_b", 3'b000, {$urandom, $urandom},
                 (i % 10 == 0) ? 64'h0 : {$urandom, $urandom}, 1'b1);
        end

        for (int i = 0; i < 200; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = rnd64();
            rb  = rnd64();
            step("rand", rop, ra, rb, 1'b1);
        end

        // Reset held one edge clears flags_q; combinational path unaffected.
        step("rst_hold", 3'b010, 64'hFFFF_FFFF_FFFF_FFFF,
             64'd1, 1'b0);
        step("rst_release", 3'b010, 64'hFFFF_FFFF_FFFF_FFFF,
             64'd1, 1'b1);
        step("after_rst", 3'b011, 64'd5, 64'd9, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
